// File: rtl/carry_lookahead_adder.sv
// Two-level carry-lookahead adder with a single registered output stage.
// Optional signed-overflow output enabled by defining CLA_OVERFLOW_EN.
module carry_lookahead_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned NG = WIDTH / GROUP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_next;

  assign g        = a & b;
  assign p        = a ^ b;
  assign sum_next = p ^ c[WIDTH-1:0];

  // Block generate/propagate, written as flat sum-of-products per group
  always_comb begin
    logic term;
    logic acc;
    term  = 1'b0;
    acc   = 1'b0;
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < int'(NG); k++) begin
      acc = 1'b0;
      for (int t = 0; t < int'(GROUP); t++) begin
        term = g[k*GROUP + t];
        for (int u = t + 1; u < int'(GROUP); u++) term = term & p[k*GROUP + u];
        acc = acc | term;
      end
      grp_g[k] = acc;
      grp_p[k] = &p[k*GROUP +: GROUP];
    end
  end

  // Second-level lookahead: every group carry-in directly from G/P and cin
  always_comb begin
    logic term;
    logic acc;
    term  = 1'b0;
    acc   = 1'b0;
    grp_c = '0;
    grp_c[0] = cin;
    for (int k = 1; k <= int'(NG); k++) begin
      acc = 1'b0;
      for (int m = 0; m < k; m++) begin
        term = grp_g[m];
        for (int u = m + 1; u < k; u++) term = term & grp_p[u];
        acc = acc | term;
      end
      term = cin;
      for (int u = 0; u < k; u++) term = term & grp_p[u];
      grp_c[k] = acc | term;
    end
  end

  // Bit carries inside each group, flat from the group carry-in
  always_comb begin
    logic term;
    logic acc;
    term = 1'b0;
    acc  = 1'b0;
    c    = '0;
    for (int k = 0; k < int'(NG); k++) begin
      c[k*GROUP] = grp_c[k];
      for (int j = 1; j < int'(GROUP); j++) begin
        acc = 1'b0;
        for (int t = 0; t < j; t++) begin
          term = g[k*GROUP + t];
          for (int u = t + 1; u < j; u++) term = term & p[k*GROUP + u];
          acc = acc | term;
        end
        term = grp_c[k];
        for (int u = 0; u < j; u++) term = term & p[k*GROUP + u];
        c[k*GROUP + j] = acc | term;
      end
    end
    c[WIDTH] = grp_c[NG];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum       <= sum_next;
      cout      <= c[WIDTH];
      out_valid <= in_valid;
    end
  end

`ifdef CLA_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= (a[WIDTH-1] == b[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);
  end
`endif

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed + random bench for carry_lookahead_adder with an expected-result queue.
// Checks overflow too when CLA_OVERFLOW_EN is defined.
module tb_carry_lookahead_adder;

  typedef struct {
    string       tag;
    logic        chk_data;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  logic        out_valid;
`ifdef CLA_OVERFLOW_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  carry_lookahead_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .out_valid(out_valid)
`ifdef CLA_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus and queue what must appear after the next edge
  task automatic drive(input string tag, input logic r, input logic v, input logic [31:0] ai,
                       input logic [31:0] bi, input logic ci, input logic chk,
                       input logic [31:0] es, input logic ec, input logic eo);
    exp_t e;
    rst = r; in_valid = v; a = ai; b = bi; cin = ci;
    e.tag = tag; e.chk_data = chk; e.sum = es; e.cout = ec; e.ovf = eo;
    e.valid = v & ~r;
    sb.push_back(e);
  endtask

  task automatic settle_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_valid"}, 33'(out_valid), 33'(e.valid));
      if (e.chk_data) begin
        check({e.tag, "_sum"}, 33'(sum), 33'(e.sum));
        check({e.tag, "_cout"}, 33'(cout), 33'(e.cout));
`ifdef CLA_OVERFLOW_EN
        check({e.tag, "_ovf"}, 33'(overflow), 33'(e.ovf));
`endif
      end
    end
  endtask

  task automatic vec(input string tag, input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                     input logic [31:0] es, input logic ec, input logic eo);
    drive(tag, 1'b0, 1'b1, ai, bi, ci, 1'b1, es, ec, eo);
    settle_and_check();
  endtask

  initial begin
    logic [32:0]  full;
    logic [31:0]  ra;
    logic [31:0]  rb;
    logic         rc;
    logic         ro;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);

    drive("reset", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    settle_and_check();

    // Directed vectors back-to-back; out_valid must stay high throughout
    vec("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    vec("neg_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    vec("ones",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    vec("mixed",    32'h0000_0010, 32'hFFFF_FFF0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    vec("chain",    32'h0000_FFFF, 32'hFFFF_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    vec("cin_rand", 32'h5A3F_2D1C, 32'h4C7E_9A8B, 1'b1, 32'hA6BD_C7A8, 1'b0, 1'b1);
    vec("rand1",    32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    vec("rand2",    32'hABCD_EF01, 32'h1234_5678, 1'b0, 32'hBE02_4579, 1'b0, 1'b0);
    vec("ones_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    vec("cin_only", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // Random operands against a plain wide-add model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom(); rb = $urandom(); rc = 1'(($urandom() % 2));
      full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      ro = (ra[31] == rb[31]) && (full[31] != ra[31]);
      vec("random", ra, rb, rc, full[31:0], full[32], ro);
    end

    // Reset wins over in_valid, then idle cycle keeps out_valid low
    drive("rst_mid", 1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    settle_and_check();
    drive("idle", 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    settle_and_check();
    vec("resume", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

    check("sb_drained", 33'(sb.size()), 33'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
